branch_target_cache: RTL and testbench
======================================

BRANCH_TARGET_CACHE -- requirements
Module: branch_target_cache

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, giving the address width in bits; the minimum legal value is 8.
REQ-002 The block SHALL have parameter NUM_ENTRY, default 16, giving the number of fully-associative entries; it SHALL be a power of two and at least 2.
REQ-003 clk_i  input  1  clock; one clock only, all state on its rising edge.
REQ-004 arst_i  input  1  reset; asynchronous and active-high.
REQ-005 flush_i  input  1  invalidates all entries.
REQ-006 pc_i  input  ADDR_W  fetch-stage lookup address.
REQ-007 upd_valid_i  input  1  execute-stage resolved control-flow instruction this cycle.
REQ-008 upd_current_i  input  ADDR_W  address of the resolved instruction.
REQ-009 upd_next_i  input  ADDR_W  resolved next address.
REQ-010 hit_o  output  1  pc_i has a valid predicted target.
REQ-011 target_o  output  ADDR_W  predicted next pc.
REQ-012 alloc_o  output  1  this cycle's update writes an entry.
REQ-013 evict_o  output  1  this cycle's write overwrites a valid entry of a different tag.
REQ-014 count_o  output  $clog2(NUM_ENTRY+1)  number of valid entries.

Function
REQ-015 Each entry SHALL store a valid bit, a tag equal to address bits [ADDR_W-1:2], and a target equal to address bits [ADDR_W-1:2]; bits [1:0] are never stored and SHALL read back as 00.
REQ-016 An update SHALL be "redirect" when upd_valid_i=1 and upd_next_i != upd_current_i+4 (modulo 2^ADDR_W), and "sequential" when upd_valid_i=1 and the two are equal.
REQ-017 Lookup SHALL be combinational: hit_o=1 if exactly one valid tag matches pc_i[ADDR_W-1:2], and target_o SHALL then be that entry's stored target concatenated with 00.
REQ-018 When hit_o=0, target_o SHALL be pc_i+4.
REQ-019 Same-cycle bypass: if a redirect update's tag equals the pc_i tag, hit_o SHALL be 1 and target_o SHALL be {upd_next_i[ADDR_W-1:2],00}.
REQ-020 Same-cycle bypass: if a sequential update's tag equals the pc_i tag, hit_o SHALL be 0.
REQ-021 A redirect whose tag matches a valid entry SHALL overwrite that entry's target, with alloc_o=1, evict_o=0 and count unchanged.
REQ-022 A redirect with no tag match SHALL write the lowest-index invalid entry, with alloc_o=1, evict_o=0 and count incremented by 1.
REQ-023 A redirect with no tag match when count=NUM_ENTRY SHALL write the entry at the round-robin victim pointer with alloc_o=1 and evict_o=1, and the pointer SHALL advance by 1, wrapping from NUM_ENTRY-1 to 0.
REQ-024 The victim pointer SHALL change only under REQ-023.
REQ-025 A sequential update matching a valid entry SHALL clear that entry's valid bit and decrement the count; with no match, no state SHALL change.
REQ-026 In all sequential cases alloc_o SHALL be 0.
REQ-027 Writes SHALL take effect at the next rising edge; lookups in the following cycle SHALL see them.
REQ-028 flush_i=1 SHALL clear all valid bits, set count to 0 and set the victim pointer to 0 at the edge, and SHALL win over a simultaneous update; alloc_o and evict_o SHALL still reflect the combinational decision.
REQ-029 The block SHALL never hold two valid entries with the same tag.

Reset
REQ-030 While arst_i=1: all valid bits=0, victim pointer=0, count_o=0, hit_o=0, target_o=pc_i+4.
REQ-031 The tag and target arrays SHALL NOT be reset.
REQ-032 Assertion of arst_i mid-update SHALL discard that update.

Structure
REQ-033 The reduced-address typedef and the default ADDR_W/NUM_ENTRY values SHALL live in the shared core package.
REQ-034 Match and free-slot index selection SHALL reuse the existing priority_encoder sub-module, one instance each; no other sub-module is needed.

Verification
REQ-035 NUM_ENTRY=4, reset → redirect upd 0x1000→0x2000 → next cycle pc_i=0x1000 gives hit_o=1, target_o=0x2000, count_o=1.
REQ-036 Five redirects with distinct tags 0x100,0x200,0x300,0x400,0x500 → fifth has evict_o=1 and overwrites entry 0; 0x100 misses and 0x500 hits.
REQ-037 Sequential upd 0x1000→0x1004 after REQ-035 → count_o=0 and pc_i=0x1000 gives hit_o=0, target_o=0x1004.
REQ-038 Same-cycle redirect 0x3000→0x4000 with pc_i=0x3000 → hit_o=1, target_o=0x4000 in that cycle.
REQ-039 flush_i with a simultaneous redirect → count_o=0 and no hit on the next cycle.
REQ-040 Redirect at upd_current_i=0xFFFF_FFFF_FFFF_FFFC to 0x0 (wrap, equals +4) → treated as sequential, no allocation.

Source files
------------

// File: rtl/branch_target_cache_pkg.sv
// branch_target_cache_pkg: shared defaults and reduced-address type for the branch target cache
package branch_target_cache_pkg;

    localparam int DEF_ADDR_W    = 64;
    localparam int DEF_NUM_ENTRY = 16;

    // Address with the two always-zero instruction-alignment bits dropped
    typedef logic [DEF_ADDR_W-3:0] red_addr_t;

endpackage

// File: rtl/branch_target_cache_priority_encoder.sv
// priority_encoder: index of the lowest set request bit plus an any-set flag
module priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    // scan downward so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_target_cache.sv
// branch_target_cache: fully-associative branch target cache with round-robin replacement
module branch_target_cache
    import branch_target_cache_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_ENTRY = DEF_NUM_ENTRY
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           flush_i,
    input  logic [ADDR_W-1:0]              pc_i,
    input  logic                           upd_valid_i,
    input  logic [ADDR_W-1:0]              upd_current_i,
    input  logic [ADDR_W-1:0]              upd_next_i,
    output logic                           hit_o,
    output logic [ADDR_W-1:0]              target_o,
    output logic                           alloc_o,
    output logic                           evict_o,
    output logic [$clog2(NUM_ENTRY+1)-1:0] count_o
);

    localparam int TW = ADDR_W - 2;
    localparam int IW = $clog2(NUM_ENTRY);
    localparam int CW = $clog2(NUM_ENTRY + 1);

    logic [TW-1:0]        tags    [NUM_ENTRY];
    logic [TW-1:0]        targets [NUM_ENTRY];
    logic [NUM_ENTRY-1:0] valid;
    logic [NUM_ENTRY-1:0] pc_match;
    logic [NUM_ENTRY-1:0] upd_match;
    logic [IW-1:0]        victim;
    logic [IW-1:0]        match_idx;
    logic [IW-1:0]        free_idx;
    logic [IW-1:0]        wr_idx;
    logic [CW-1:0]        count;
    logic                 match_any;
    logic                 free_any;
    logic                 redirect;
    logic                 sequential;
    logic [TW-1:0]        pc_tag;
    logic [TW-1:0]        upd_tag;
    logic [TW-1:0]        hit_tgt;
    logic [ADDR_W-1:0]    pc_p4;

    assign pc_tag     = pc_i[ADDR_W-1:2];
    assign upd_tag    = upd_current_i[ADDR_W-1:2];
    assign pc_p4      = pc_i + ADDR_W'(4);
    assign redirect   = upd_valid_i && (upd_next_i != upd_current_i + ADDR_W'(4));
    assign sequential = upd_valid_i && !redirect;
    assign count_o    = count;

    // a redirect always writes; reset suppresses it so a mid-update reset drops the write
    assign alloc_o = !arst_i && redirect;
    assign evict_o = alloc_o && !match_any && !free_any;
    assign wr_idx  = match_any ? match_idx : (free_any ? free_idx : victim);

    priority_encoder #(.N(NUM_ENTRY)) u_match (
        .req   (upd_match),
        .idx   (match_idx),
        .valid (match_any)
    );

    priority_encoder #(.N(NUM_ENTRY)) u_free (
        .req   (~valid),
        .idx   (free_idx),
        .valid (free_any)
    );

    // tag compare for both the fetch lookup and the update port, plus one-hot target select
    always_comb begin
        pc_match  = '0;
        upd_match = '0;
        hit_tgt   = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            pc_match[i]  = valid[i] && (tags[i] == pc_tag);
            upd_match[i] = valid[i] && (tags[i] == upd_tag);
            hit_tgt      = hit_tgt | (pc_match[i] ? targets[i] : '0);
        end
    end

    // lookup result; an update to the same tag this cycle overrides stored state
    always_comb begin
        hit_o    = 1'b0;
        target_o = pc_p4;
        if (!arst_i) begin
            if (upd_valid_i && upd_tag == pc_tag) begin
                hit_o    = redirect;
                target_o = redirect ? {upd_next_i[ADDR_W-1:2], 2'b00} : pc_p4;
            end else if ($onehot(pc_match)) begin
                hit_o    = 1'b1;
                target_o = {hit_tgt, 2'b00};
            end
        end
    end

    // valid bits, occupancy count and replacement pointer; flush beats any update
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            valid  <= '0;
            count  <= '0;
            victim <= '0;
        end else if (flush_i) begin
            valid  <= '0;
            count  <= '0;
            victim <= '0;
        end else begin
            if (alloc_o)
                valid[wr_idx] <= 1'b1;
            if (alloc_o && !match_any && free_any)
                count <= count + CW'(1);
            if (evict_o)
                victim <= victim + IW'(1);
            if (sequential && match_any) begin
                valid[match_idx] <= 1'b0;
                count            <= count - CW'(1);
            end
        end
    end

    // tag and target storage carries no reset; the valid bits qualify it
    always_ff @(posedge clk_i) begin
        if (alloc_o) begin
            tags[wr_idx]    <= upd_tag;
            targets[wr_idx] <= upd_next_i[ADDR_W-1:2];
        end
    end

endmodule

// File: tb/tb_branch_target_cache.sv
// tb_branch_target_cache: scoreboard bench for the branch target cache with 4 entries
module tb_branch_target_cache;

    typedef struct packed {
        logic        hit;
        logic [63:0] tgt;
        logic        alloc;
        logic        evict;
        logic [2:0]  cnt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [63:0] pc_i = '0;
    logic        upd_valid_i = 1'b0;
    logic [63:0] upd_current_i = '0;
    logic [63:0] upd_next_i = '0;
    logic        hit_o;
    logic [63:0] target_o;
    logic        alloc_o;
    logic        evict_o;
    logic [2:0]  count_o;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    logic        m_v   [4];
    logic [61:0] m_tag [4];
    logic [61:0] m_tgt [4];
    int          m_cnt = 0;
    int          m_vic = 0;

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    branch_target_cache #(.ADDR_W(64), .NUM_ENTRY(4)) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .flush_i       (flush_i),
        .pc_i          (pc_i),
        .upd_valid_i   (upd_valid_i),
        .upd_current_i (upd_current_i),
        .upd_next_i    (upd_next_i),
        .hit_o         (hit_o),
        .target_o      (target_o),
        .alloc_o       (alloc_o),
        .evict_o       (evict_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [63:0] pc, input logic uv, input logic [63:0] cur,
                         input logic [63:0] nxt, input logic fl, input logic eh,
                         input logic [63:0] et, input logic ea, input logic ee, input logic [2:0] ec);
        pc_i          = pc;
        upd_valid_i   = uv;
        upd_current_i = cur;
        upd_next_i    = nxt;
        flush_i       = fl;
        sb.push_back('{hit: eh, tgt: et, alloc: ea, evict: ee, cnt: ec});
    endtask

    function automatic exp_t m_eval(input logic [63:0] pc, input logic uv, input logic [63:0] cur,
                                    input logic [63:0] nxt);
        exp_t r;
        logic redir;
        bit   found;
        redir = uv && (nxt != cur + 64'd4);
        r.hit = 1'b0;
        r.tgt = pc + 64'd4;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i] && m_tag[i] == pc[63:2]) begin
                r.hit = 1'b1;
                r.tgt = {m_tgt[i], 2'b00};
            end
            if (m_v[i] && m_tag[i] == cur[63:2])
                found = 1'b1;
        end
        if (uv && cur[63:2] == pc[63:2]) begin
            r.hit = redir;
            r.tgt = redir ? {nxt[63:2], 2'b00} : pc + 64'd4;
        end
        r.alloc = redir;
        r.evict = redir && !found && m_cnt == 4;
        r.cnt   = 3'(m_cnt);
        return r;
    endfunction

    task automatic m_commit(input logic uv, input logic [63:0] cur, input logic [63:0] nxt, input logic fl);
        int hit_at = -1;
        int free_at = -1;
        if (fl) begin
            for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
            m_cnt = 0;
            m_vic = 0;
            return;
        end
        if (!uv) return;
        for (int i = 3; i >= 0; i--) begin
            if (m_v[i] && m_tag[i] == cur[63:2]) hit_at = i;
            if (!m_v[i]) free_at = i;
        end
        if (nxt != cur + 64'd4) begin
            if (hit_at >= 0) begin
                m_tgt[hit_at] = nxt[63:2];
            end else if (free_at >= 0) begin
                m_v[free_at] = 1'b1; m_tag[free_at] = cur[63:2]; m_tgt[free_at] = nxt[63:2];
                m_cnt++;
            end else begin
                m_tag[m_vic] = cur[63:2]; m_tgt[m_vic] = nxt[63:2];
                m_vic = (m_vic + 1) % 4;
            end
        end else if (hit_at >= 0) begin
            m_v[hit_at] = 1'b0;
            m_cnt--;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            case (k)
                0: drive(64'h1000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h1004, 1'b0, 1'b0, 3'd0);
                default: drive(TOP, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 3'd0);
            endcase
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL reset row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
        arst_i = 1'b0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: drive(64'h1000, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b1, 64'h2000, 1'b1, 1'b0, 3'd0);
                1: drive(64'h1000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h2000, 1'b0, 1'b0, 3'd1);
                2: drive(64'h1000, 1'b1, 64'h1000, 64'h1004, 1'b0, 1'b0, 64'h1004, 1'b0, 1'b0, 3'd1);
                3: drive(64'h1000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h1004, 1'b0, 1'b0, 3'd0);
                4: drive(64'h5000, 1'b1, 64'h5000, 64'h5004, 1'b0, 1'b0, 64'h5004, 1'b0, 1'b0, 3'd0);
                default: drive(64'h0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h4, 1'b0, 1'b0, 3'd0);
            endcase
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL basic row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_update_existing();
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: drive(64'h3000, 1'b1, 64'h3000, 64'h4000, 1'b0, 1'b1, 64'h4000, 1'b1, 1'b0, 3'd0);
                1: drive(64'h3000, 1'b1, 64'h3000, 64'h8000, 1'b0, 1'b1, 64'h8000, 1'b1, 1'b0, 3'd1);
                2: drive(64'h3000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000, 1'b0, 1'b0, 3'd1);
                3: drive(64'h3002, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h8000, 1'b0, 1'b0, 3'd1);
                4: drive(64'h10, 1'b1, 64'h3000, 64'h9003, 1'b0, 1'b0, 64'h14, 1'b1, 1'b0, 3'd1);
                default: drive(64'h3000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h9000, 1'b0, 1'b0, 3'd1);
            endcase
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL update_existing row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: drive(64'h3000, 1'b1, 64'h6000, 64'h7000, 1'b1, 1'b1, 64'h9000, 1'b1, 1'b0, 3'd1);
                1: drive(64'h6000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h6004, 1'b0, 1'b0, 3'd0);
                default: drive(64'h3000, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h3004, 1'b0, 1'b0, 3'd0);
            endcase
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL flush row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_evict();
        for (int k = 0; k < 17; k++) begin
            case (k)
                0: drive(64'h0, 1'b1, 64'h100, 64'h1100, 1'b0, 1'b0, 64'h4, 1'b1, 1'b0, 3'd0);
                1: drive(64'h0, 1'b1, 64'h200, 64'h1200, 1'b0, 1'b0, 64'h4, 1'b1, 1'b0, 3'd1);
                2: drive(64'h0, 1'b1, 64'h300, 64'h1300, 1'b0, 1'b0, 64'h4, 1'b1, 1'b0, 3'd2);
                3: drive(64'h0, 1'b1, 64'h400, 64'h1400, 1'b0, 1'b0, 64'h4, 1'b1, 1'b0, 3'd3);
                4: drive(64'h0, 1'b1, 64'h500, 64'h1500, 1'b0, 1'b0, 64'h4, 1'b1, 1'b1, 3'd4);
                5: drive(64'h100, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h104, 1'b0, 1'b0, 3'd4);
                6: drive(64'h500, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1500, 1'b0, 1'b0, 3'd4);
                7: drive(64'h200, 1'b1, 64'h600, 64'h1600, 1'b0, 1'b1, 64'h1200, 1'b1, 1'b1, 3'd4);
                8: drive(64'h200, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h204, 1'b0, 1'b0, 3'd4);
                9: drive(64'h300, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1300, 1'b0, 1'b0, 3'd4);
                10: drive(64'h0, 1'b1, 64'h300, 64'h304, 1'b0, 1'b0, 64'h4, 1'b0, 1'b0, 3'd4);
                11: drive(64'h300, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h304, 1'b0, 1'b0, 3'd3);
                12: drive(64'h0, 1'b1, 64'h700, 64'h1700, 1'b0, 1'b0, 64'h4, 1'b1, 1'b0, 3'd3);
                13: drive(64'h700, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1700, 1'b0, 1'b0, 3'd4);
                14: drive(64'h0, 1'b1, 64'h800, 64'h1800, 1'b0, 1'b0, 64'h4, 1'b1, 1'b1, 3'd4);
                15: drive(64'h700, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h704, 1'b0, 1'b0, 3'd4);
                default: drive(64'h400, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h1400, 1'b0, 1'b0, 3'd4);
            endcase
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL evict row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: drive(TOP, 1'b1, TOP, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 3'd4);
                1: drive(TOP, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 3'd4);
                2: drive(64'h0, 1'b1, TOP, 64'h4, 1'b0, 1'b0, 64'h4, 1'b1, 1'b1, 3'd4);
                default: drive(TOP, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 64'h4, 1'b0, 1'b0, 3'd4);
            endcase
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL wrap row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            arst_i = (k == 0);
            drive(TOP, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 3'd0);
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL async_reset row %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_random();
        logic [63:0] pc, cur, nxt;
        logic        uv, fl;
        exp_t        ex;
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        m_cnt = 0;
        m_vic = 0;
        for (int k = 0; k < 400; k++) begin
            pc  = 64'($urandom_range(1, 7)) << 6;
            cur = 64'($urandom_range(1, 7)) << 6;
            uv  = ($urandom_range(0, 4) != 0);
            nxt = ($urandom_range(0, 1) == 1) ? cur + 64'd4 : (64'h8000 + 64'($urandom_range(0, 63)));
            fl  = ($urandom_range(0, 24) == 0);
            ex  = m_eval(pc, uv, cur, nxt);
            drive(pc, uv, cur, nxt, fl, ex.hit, ex.tgt, ex.alloc, ex.evict, ex.cnt);
            @(negedge clk_i);
            e = sb.pop_front();
            vectors++;
            if (hit_o !== e.hit || target_o !== e.tgt || alloc_o !== e.alloc || evict_o !== e.evict || count_o !== e.cnt) begin
                miscompares++;
                $display("FAIL random cycle %0d: got hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d want hit=%0b tgt=%h alloc=%0b evict=%0b cnt=%0d",
                         k, hit_o, target_o, alloc_o, evict_o, count_o, e.hit, e.tgt, e.alloc, e.evict, e.cnt);
            end
            @(posedge clk_i); #1;
            m_commit(uv, cur, nxt, fl);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_update_existing();
        test_flush();
        test_evict();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
